rtc_bus_sequencer: RTL
======================

Name: rtc_bus_sequencer

Overview:
Parametrised bus-cycle sequencer for the multiplexed address/data RTC bus. It is the successor to the fixed 12-cycle init-write timing generator. Each transaction runs an address phase (AD low, address driven) and then a data phase (write or read), with programmable setup, strobe and hold widths. A start/busy/done handshake serves the init and read/write controller FSMs, and read data is captured for the display path.

Parameters:
DATA_W, 8, width of the multiplexed address/data bus
T_SETUP, 1, cycles CS low before the strobe falls (>=1)
T_PULSE, 6, cycles the WR/RD strobe is held low (>=1)
T_HOLD, 2, cycles CS stays low after the strobe rises (>=1)
T_GAP, 2, cycles CS is high between the address and data phases (>=1)
CNT_W, 4, phase counter width; must hold max(T_*)-1

Ports:
clkAD  in  1  system clock
resetAD  in  1  asynchronous, active-high reset
start  in  1  request; accepted only in IDLE
op  in  2  00 WRITE, 01 READ, 10 ADDR_ONLY, 11 treated as WRITE
addr  in  DATA_W  register address
wdata  in  DATA_W  write data
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
rdata  out  DATA_W  last read data
bus_in  in  DATA_W  sampled bus value
bus_out  out  DATA_W  value driven on bus when DIR=1
CS  out  1  chip select, active low
RD  out  1  read strobe, active low
WR  out  1  write strobe, active low
AD  out  1  0 = address phase, 1 = data/idle
DIR  out  1  1 = FPGA drives bus; top level tristates on DIR

Behaviour:
- Reset (async): state IDLE, counter 0; CS=1, RD=1, WR=1, AD=1, DIR=0, busy=0, done=0, rdata=0, bus_out=0. Reset mid-transaction aborts immediately and no done is issued.
- All bus outputs are registered and decoded from next-state, so they change on the same edge as the state, glitch-free.
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE. Each timed state lasts its T_* cycles via a down-counter loaded on entry.
- IDLE, start=1: latch op/addr/wdata and go to A_SETUP. Later input changes are ignored. start while busy (including the DONE cycle) is ignored, with no queueing.
- A_*: AD=0, DIR=1, bus_out=addr, CS=0. WR=0 only in A_PULSE; RD=1.
- A_HOLD exit: ADDR_ONLY goes to DONE; otherwise go to GAP (CS=1, DIR=0, AD=1).
- D_*: AD=1, CS=0.
  - WRITE: DIR=1, bus_out=wdata, WR=0 only in D_PULSE.
  - READ: DIR=0, RD=0 only in D_PULSE.
- READ capture: rdata <= bus_in on the edge leaving D_PULSE. rdata otherwise holds, and is unchanged by writes.
- DONE: done=1 and busy=1 for one cycle, all bus signals idle, then IDLE. busy=1 from the accept edge through DONE.
- Back-to-back: start in the first IDLE cycle after DONE is accepted; CS stays high at least 1 cycle between transactions.
- Timing with defaults, start accepted at edge e0:
  - CS falls e0, WR falls e1, WR rises e7, CS rises e9.
  - GAP spans e9..e11.
  - CS falls e11, strobe falls e12, strobe rises e18, CS rises e20.
  - done high e20..e21, IDLE at e21.
  - ADDR_ONLY: done at e9..e10.

Decomposition:
- Package rtc_bus_pkg holds:
  - op codes OP_WRITE/OP_READ/OP_ADDR_ONLY
  - state encoding
  - default timing constants
- One sub-module, bus_phase_timer: loadable down-counter of CNT_W bits with a load value input and a last-cycle flag. The FSM instantiates it once and reloads it on every state entry.

Test Plan:
- Reset, then WRITE addr=0x21 wdata=0x5A with defaults -> CS low e0..e9 and e11..e20, WR low e1..e7 and e12..e18, AD=0 only e0..e9, bus_out 0x21 then 0x5A, DIR=0 in GAP, done pulse at e20.
- READ addr=0x33, bus_in=0xC4 during D_PULSE -> RD low e12..e18, WR stays 1, DIR=0 in data phase, rdata=0xC4 at e18, done at e20.
- ADDR_ONLY addr=0xF0 -> single address phase, no GAP/data phase, done at e9, busy falls at e10.
- start pulsed at e3 and again in the DONE cycle, with addr changed mid-transaction -> both ignored, bus_out keeps the latched addr; start at e21 accepted.
- resetAD asserted at e14 of a READ -> outputs idle asynchronously, no done, rdata keeps its previous value; a new transaction afterwards runs normally.
- Parameters T_SETUP=2, T_PULSE=3, T_HOLD=1, T_GAP=1 with a WRITE -> WR low e2..e5, CS rises e6, CS falls again e7, done at e13.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared op codes, FSM state encoding and default bus timing for the RTC bus sequencer.
package rtc_bus_pkg;

  localparam logic [1:0] OP_WRITE     = 2'b00;
  localparam logic [1:0] OP_READ      = 2'b01;
  localparam logic [1:0] OP_ADDR_ONLY = 2'b10;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_A_SETUP = 4'd1;
  localparam logic [3:0] S_A_PULSE = 4'd2;
  localparam logic [3:0] S_A_HOLD  = 4'd3;
  localparam logic [3:0] S_GAP     = 4'd4;
  localparam logic [3:0] S_D_SETUP = 4'd5;
  localparam logic [3:0] S_D_PULSE = 4'd6;
  localparam logic [3:0] S_D_HOLD  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_T_SETUP = 1;
  localparam int DEF_T_PULSE = 6;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_GAP   = 2;
  localparam int DEF_CNT_W   = 4;

  // Op code 11 is deliberately folded into WRITE.
  function automatic logic is_read_op(input logic [1:0] op);
    return op == OP_READ;
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable phase down-counter; last is high during the final cycle of a phase.
module bus_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clkAD,
  input  logic             resetAD,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clkAD or posedge resetAD) begin
    if (resetAD) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Address-then-data bus cycle sequencer for the multiplexed RTC bus, with
// programmable setup/strobe/hold/gap widths and a start/busy/done handshake.
//
// state     | meaning
// IDLE      | bus idle, waiting for start
// A_SETUP   | address driven, CS low, before WR strobe
// A_PULSE   | address strobe (WR low)
// A_HOLD    | address held after strobe
// GAP       | CS high between address and data phases
// D_SETUP   | data phase, CS low, before strobe
// D_PULSE   | WR or RD strobe low; read data captured on exit
// D_HOLD    | data phase hold after strobe
// DONE      | one-cycle completion pulse, bus idle
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_GAP   = DEF_T_GAP,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clkAD,
  input  logic              resetAD,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic              AD,
  output logic              DIR
);

  logic [3:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, bus_out_q, bus_out_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, ad_q, ad_d, dir_q, dir_d;
  logic              tmr_load, tmr_last;
  logic [CNT_W-1:0]  tmr_val;

  function automatic logic [CNT_W-1:0] phase_len(input logic [3:0] s);
    case (s)
      S_A_SETUP, S_D_SETUP: return CNT_W'(T_SETUP - 1);
      S_A_PULSE, S_D_PULSE: return CNT_W'(T_PULSE - 1);
      S_A_HOLD,  S_D_HOLD:  return CNT_W'(T_HOLD - 1);
      S_GAP:                return CNT_W'(T_GAP - 1);
      default:              return '0;
    endcase
  endfunction

  bus_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clkAD    (clkAD),
    .resetAD  (resetAD),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_A_SETUP;
        op_d    = op;
        addr_d  = addr;
        wdata_d = wdata;
      end
      S_A_SETUP: if (tmr_last) state_d = S_A_PULSE;
      S_A_PULSE: if (tmr_last) state_d = S_A_HOLD;
      S_A_HOLD:  if (tmr_last) state_d = (op_q == OP_ADDR_ONLY) ? S_DONE : S_GAP;
      S_GAP:     if (tmr_last) state_d = S_D_SETUP;
      S_D_SETUP: if (tmr_last) state_d = S_D_PULSE;
      S_D_PULSE: if (tmr_last) begin
        state_d = S_D_HOLD;
        if (is_read_op(op_q)) rdata_d = bus_in;
      end
      S_D_HOLD:  if (tmr_last) state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    tmr_load = (state_d != state_q);
    tmr_val  = phase_len(state_d);
  end

  // Bus pins decode the next state so they switch on the same edge as the FSM.
  always_comb begin
    cs_d      = 1'b1;
    rd_d      = 1'b1;
    wr_d      = 1'b1;
    ad_d      = 1'b1;
    dir_d     = 1'b0;
    bus_out_d = '0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    case (state_d)
      S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
        cs_d      = 1'b0;
        ad_d      = 1'b0;
        dir_d     = 1'b1;
        bus_out_d = addr_d;
        wr_d      = (state_d != S_A_PULSE);
      end
      S_D_SETUP, S_D_PULSE, S_D_HOLD: begin
        cs_d = 1'b0;
        if (is_read_op(op_d)) begin
          rd_d = (state_d != S_D_PULSE);
        end else begin
          dir_d     = 1'b1;
          bus_out_d = wdata_d;
          wr_d      = (state_d != S_D_PULSE);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkAD or posedge resetAD) begin
    if (resetAD) begin
      state_q   <= S_IDLE;
      op_q      <= OP_WRITE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      ad_q      <= 1'b1;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_out_q <= bus_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ad_q      <= ad_d;
      dir_q     <= dir_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign bus_out = bus_out_q;
  assign CS      = cs_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign AD      = ad_q;
  assign DIR     = dir_q;

endmodule
